// File: rtl/upsampling_pkg.sv
// Shared geometry, widths and FSM state type for the 2x nearest-neighbour upsampler.
package upsampling_pkg;

    localparam int RESOLUTION         = 8;
    localparam int IMG_SIDE           = 28;
    localparam int POOL_SIDE          = 14;
    localparam int PIXELS_NUMBER      = IMG_SIDE * IMG_SIDE;
    localparam int AVERAGED_PIXELS_NR = POOL_SIDE * POOL_SIDE;
    localparam int COORD_W            = 5;
    localparam int SRC_IDX_W          = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/pixels_upsampling_if.sv
// Pooled-frame input and upsampled pixel output handshakes.
// PIXELS_UPSAMPLING_COORD_EN adds the out_row/out_col coordinate outputs.
interface pixels_upsampling_if;

    logic                                                                        in_valid;
    logic                                                                        in_ready;
    logic [upsampling_pkg::RESOLUTION*upsampling_pkg::AVERAGED_PIXELS_NR-1:0]    pixels_averaged;
    logic                                                                        out_valid;
    logic                                                                        out_ready;
    logic [upsampling_pkg::RESOLUTION-1:0]                                       out_pixel;
    logic                                                                        out_last;
`ifdef PIXELS_UPSAMPLING_COORD_EN
    logic [upsampling_pkg::COORD_W-1:0]                                          out_row;
    logic [upsampling_pkg::COORD_W-1:0]                                          out_col;
`endif

    modport slave (
        input  in_valid, pixels_averaged, out_ready,
        output in_ready, out_valid, out_pixel, out_last
`ifdef PIXELS_UPSAMPLING_COORD_EN
        , output out_row, out_col
`endif
    );

    modport master (
        output in_valid, pixels_averaged, out_ready,
        input  in_ready, out_valid, out_pixel, out_last
`ifdef PIXELS_UPSAMPLING_COORD_EN
        , input out_row, out_col
`endif
    );

endinterface

// File: rtl/upsample_addr_gen.sv
// Raster row/col counters over the 28x28 output and the matching 14x14 source index.
module upsample_addr_gen
    import upsampling_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 advance_i,
    output logic [COORD_W-1:0]   row_o,
    output logic [COORD_W-1:0]   col_o,
    output logic                 last_o,
    output logic [SRC_IDX_W-1:0] src_idx_o
);

    localparam logic [COORD_W-1:0]   SIDE_MAX  = COORD_W'(IMG_SIDE - 1);
    localparam logic [SRC_IDX_W-1:0] POOL_W    = SRC_IDX_W'(POOL_SIDE);

    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (col_q == SIDE_MAX) begin
                col_d = '0;
                row_d = (row_q == SIDE_MAX) ? '0 : row_q + COORD_W'(1);
            end else begin
                col_d = col_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == SIDE_MAX) && (col_q == SIDE_MAX);

    // Dropping the LSB of each coordinate replicates every source pixel over a 2x2 block.
    assign src_idx_o = {{(SRC_IDX_W-COORD_W+1){1'b0}}, row_q[COORD_W-1:1]} * POOL_W
                     + {{(SRC_IDX_W-COORD_W+1){1'b0}}, col_q[COORD_W-1:1]};

endmodule

// File: rtl/pixels_upsampling.sv
// 14x14 -> 28x28 nearest-neighbour upsampler: frame buffer, FSM and output mux.
// Optional PIXELS_UPSAMPLING_COORD_EN exposes the current row/col on the output side.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | in_ready=1, waiting for a pooled frame to capture
//  STREAM | emitting 784 pixels in raster order, input side ignored
module pixels_upsampling
    import upsampling_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    pixels_upsampling_if.slave bus
);

    state_t                 state_q;
    logic                   out_valid_q;
    logic [RESOLUTION-1:0]  frame_q [AVERAGED_PIXELS_NR];

    logic                   capture;
    logic                   advance;
    logic                   last;
    logic [COORD_W-1:0]     row;
    logic [COORD_W-1:0]     col;
    logic [SRC_IDX_W-1:0]   src_idx;

    assign capture = bus.in_valid && (state_q == IDLE);
    assign advance = out_valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        state_q     <= STREAM;
                        out_valid_q <= 1'b1;
                    end
                end
                STREAM: begin
                    if (advance && last) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Buffer is deliberately not reset; it is only read while streaming a captured frame.
    always_ff @(posedge clk) begin
        if (capture && !reset) begin
            for (int k = 0; k < AVERAGED_PIXELS_NR; k++) begin
                frame_q[k] <= bus.pixels_averaged[k*RESOLUTION +: RESOLUTION];
            end
        end
    end

    upsample_addr_gen u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (capture),
        .advance_i (advance),
        .row_o     (row),
        .col_o     (col),
        .last_o    (last),
        .src_idx_o (src_idx)
    );

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_pixel = out_valid_q ? frame_q[src_idx] : '0;
    assign bus.out_last  = out_valid_q && last;

`ifdef PIXELS_UPSAMPLING_COORD_EN
    assign bus.out_row = out_valid_q ? row : '0;
    assign bus.out_col = out_valid_q ? col : '0;
`else
    logic unused_coord;
    assign unused_coord = ^{row, col};
`endif

endmodule

// File: tb/tb_pixels_upsampling.sv
// Scoreboard bench for pixels_upsampling: directed frames, stalls, reset and back-to-back capture.
module tb_pixels_upsampling;
    import upsampling_pkg::*;

    typedef struct {
        logic [7:0] pix;
        logic       last;
        int         row;
        int         col;
    } exp_t;

    exp_t       sb_q [$];
    logic       clk = 1'b0;
    logic       reset;
    int         total = 0;
    int         bad = 0;
    int         hs_count = 0;
    int         last_count = 0;
    logic [7:0] src [AVERAGED_PIXELS_NR];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_pix;
    logic       prev_last;

    pixels_upsampling_if u_if ();

    pixels_upsampling dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bus();
        for (int k = 0; k < AVERAGED_PIXELS_NR; k++)
            u_if.pixels_averaged[k*8 +: 8] = src[k];
    endtask

    task automatic load_ramp();
        for (int k = 0; k < AVERAGED_PIXELS_NR; k++) src[k] = 8'(k);
        drive_bus();
    endtask

    task automatic load_const(input logic [7:0] v);
        for (int k = 0; k < AVERAGED_PIXELS_NR; k++) src[k] = v;
        drive_bus();
    endtask

    task automatic load_rand();
        for (int k = 0; k < AVERAGED_PIXELS_NR; k++) src[k] = 8'($urandom_range(0, 255));
        drive_bus();
    endtask

    // Model: output pixel k at (k/28, k%28) comes from pooled pixel (r/2, c/2).
    task automatic push_frame();
        exp_t e;
        for (int k = 0; k < PIXELS_NUMBER; k++) begin
            e.row  = k / 28;
            e.col  = k % 28;
            e.pix  = src[(e.row / 2) * 14 + (e.col / 2)];
            e.last = (k == PIXELS_NUMBER - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done(input bit rand_ready, input int limit);
        int n = 0;
        while ((u_if.out_valid !== 1'b0 || sb_q.size() != 0) && n < limit) begin
            u_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        u_if.out_ready = 1'b1;
        check("frame_drain_within_budget", (n < limit), 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && u_if.out_valid === 1'b1) begin
                check("stall_hold_pixel", u_if.out_pixel, prev_pix);
                check("stall_hold_last", u_if.out_last, prev_last);
            end
            if (u_if.out_valid === 1'b1 && u_if.out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pixel_sb_size", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check("pixel", u_if.out_pixel, e.pix);
                    check("last", u_if.out_last, e.last);
`ifdef PIXELS_UPSAMPLING_COORD_EN
                    check("row", u_if.out_row, e.row);
                    check("col", u_if.out_col, e.col);
`endif
                end
                hs_count++;
                if (u_if.out_last === 1'b1) last_count++;
            end else if (u_if.out_valid === 1'b0) begin
                check("idle_pixel_zero", u_if.out_pixel, 0);
                check("idle_last_zero", u_if.out_last, 0);
`ifdef PIXELS_UPSAMPLING_COORD_EN
                check("idle_row_zero", u_if.out_row, 0);
                check("idle_col_zero", u_if.out_col, 0);
`endif
            end
            prev_stall = (u_if.out_valid === 1'b1) && (u_if.out_ready === 1'b0);
            prev_pix   = u_if.out_pixel;
            prev_last  = u_if.out_last;
        end
    end

    initial begin
        int hs0;
        int l0;
        reset = 1'b1;
        u_if.in_valid = 1'b0;
        u_if.out_ready = 1'b1;
        u_if.pixels_averaged = '0;
        repeat (3) step();
        reset = 1'b0;
        check("rst_in_ready", u_if.in_ready, 1);
        check("rst_out_valid", u_if.out_valid, 0);
        check("rst_out_pixel", u_if.out_pixel, 0);
        check("rst_out_last", u_if.out_last, 0);
        step();

        // Ramp frame, no backpressure, exact cycle timing.
        load_ramp();
        u_if.in_valid = 1'b1;
        hs0 = hs_count;
        l0 = last_count;
        step();
        u_if.in_valid = 1'b0;
        push_frame();
        check("t1_valid_n1", u_if.out_valid, 1);
        check("t1_in_ready_n1", u_if.in_ready, 0);
        check("t1_pix_0_0", u_if.out_pixel, 0);
        repeat (2) step();
        check("t1_pix_0_2", u_if.out_pixel, 1);
        repeat (781) step();
        check("t1_valid_n784", u_if.out_valid, 1);
        check("t1_last_n784", u_if.out_last, 1);
        check("t1_pix_27_27", u_if.out_pixel, 195);
        step();
        check("t1_in_ready_n785", u_if.in_ready, 1);
        check("t1_valid_n785", u_if.out_valid, 0);
        check("t1_handshakes", hs_count - hs0, 784);
        check("t1_last_count", last_count - l0, 1);
        check("t1_sb_empty", sb_q.size(), 0);

        // Ramp frame under random backpressure.
        load_ramp();
        u_if.in_valid = 1'b1;
        step();
        u_if.in_valid = 1'b0;
        push_frame();
        wait_done(1'b1, 5000);

        // Frame A then B (0xAA) held on the bus with in_valid during A's stream.
        load_rand();
        u_if.in_valid = 1'b1;
        step();
        push_frame();
        load_const(8'hAA);
        repeat (784) step();
        check("t3_in_ready_n785", u_if.in_ready, 1);
        check("t3_valid_n785", u_if.out_valid, 0);
        push_frame();
        step();
        u_if.in_valid = 1'b0;
        check("t3_b_valid", u_if.out_valid, 1);
        check("t3_b_pix", u_if.out_pixel, 8'hAA);
        wait_done(1'b0, 2000);

        // Reset after 300 handshakes.
        load_ramp();
        u_if.in_valid = 1'b1;
        hs0 = hs_count;
        step();
        u_if.in_valid = 1'b0;
        push_frame();
        repeat (300) step();
        reset = 1'b1;
        step();
        check("t4_rst_valid", u_if.out_valid, 0);
        check("t4_rst_pixel", u_if.out_pixel, 0);
        check("t4_rst_in_ready", u_if.in_ready, 1);
        check("t4_rst_last", u_if.out_last, 0);
        check("t4_handshakes", hs_count - hs0, 300);
        sb_q.delete();
        reset = 1'b0;
        step();
        load_rand();
        u_if.in_valid = 1'b1;
        step();
        u_if.in_valid = 1'b0;
        push_frame();
        wait_done(1'b1, 5000);
        step();
        check("end_in_ready", u_if.in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
